mem_bus_arbiter: RTL and testbench

//  Shares the single proc2mem/mem2proc port between the I-cache fetch path and the D-cache.

---
 rtl/mem_bus_arbiter_pkg.sv | 25 ++
 rtl/mem_bus_arbiter_tag_table.sv | 52 +++++
 rtl/mem_bus_arbiter.sv | 79 +++++++
 tb/tb_mem_bus_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: bus commands, sizes, tag type and requester ids shared by the arbiter slice
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_command_e;

    localparam logic [1:0] BYTE   = 2'd0;
    localparam logic [1:0] HALF   = 2'd1;
    localparam logic [1:0] WORD   = 2'd2;
    localparam logic [1:0] DOUBLE = 2'd3;

    localparam int NUM_TAGS_DEF   = 16;
    localparam int MAX_DC_RUN_DEF = 4;

    typedef logic [3:0] mem_tag_t;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } requester_e;

endpackage

// File: rtl/mem_bus_arbiter_tag_table.sv
// mem_tag_table: tracks owner and staleness of every outstanding load tag and classifies returns
module mem_tag_table
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_TAGS = NUM_TAGS_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       alloc_en,
    input  mem_tag_t   alloc_tag,
    input  requester_e alloc_owner,
    input  logic       squash,
    input  mem_tag_t   ret_tag,
    output logic       ic_hit,
    output logic       dc_hit,
    output logic       stray
);

    logic [NUM_TAGS-1:0] live, owner_dc, stale;
    logic [NUM_TAGS-1:0] alloc_oh, ret_oh, squash_mask;
    logic                hit;

    // one-hot views of this cycle's allocate/return and of entries a flush marks stale
    always_comb begin
        alloc_oh    = alloc_en ? (NUM_TAGS'(1) << alloc_tag) : '0;
        ret_oh      = (ret_tag != '0) ? (NUM_TAGS'(1) << ret_tag) : '0;
        squash_mask = squash ? (live & ~owner_dc) : '0;
    end

    // table update; an allocate overrides a return of the same tag in the same cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            live     <= '0;
            owner_dc <= '0;
            stale    <= '0;
        end else begin
            live     <= (live & ~ret_oh) | alloc_oh;
            owner_dc <= (alloc_owner == REQ_DC) ? (owner_dc | alloc_oh) : (owner_dc & ~alloc_oh);
            stale    <= ((stale | squash_mask) & ~alloc_oh)
                        | ((squash && alloc_owner == REQ_IC) ? alloc_oh : '0);
        end
    end

    // return classification; tag 0 is never live so it never hits
    always_comb begin
        hit    = live[ret_tag];
        dc_hit = hit && owner_dc[ret_tag];
        ic_hit = hit && !owner_dc[ret_tag] && !stale[ret_tag] && !squash;
        stray  = !reset && (ret_tag != '0) && !hit;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the memory port between I-cache and D-cache and routes tagged returns
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_TAGS   = NUM_TAGS_DEF,
    parameter int MAX_DC_RUN = MAX_DC_RUN_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    input  logic        ic_squash,
    output mem_tag_t    ic_response,
    output logic [63:0] ic_data,
    output mem_tag_t    ic_tag,
    input  logic [1:0]  dc_command,
    input  logic [31:0] dc_addr,
    input  logic [63:0] dc_wdata,
    input  logic [1:0]  dc_size,
    output mem_tag_t    dc_response,
    output logic [63:0] dc_data,
    output mem_tag_t    dc_tag,
    output logic [1:0]  proc2mem_command,
    output logic [31:0] proc2mem_addr,
    output logic [63:0] proc2mem_data,
    output logic [1:0]  proc2mem_size,
    input  mem_tag_t    mem2proc_response,
    input  logic [63:0] mem2proc_data,
    input  mem_tag_t    mem2proc_tag,
    output logic        stray_tag
);

    localparam int RW = $clog2(MAX_DC_RUN + 1);

    logic [RW-1:0] run_cnt;
    logic          dc_grant, ic_grant, ic_hit, dc_hit, alloc_en;

    // grant mux: D-cache has priority until the I-cache has waited MAX_DC_RUN grants
    always_comb begin
        dc_grant         = !reset && (dc_command != BUS_NONE)
                           && !(ic_req && run_cnt == RW'(MAX_DC_RUN));
        ic_grant         = !reset && ic_req && !dc_grant;
        proc2mem_command = dc_grant ? dc_command : (ic_grant ? BUS_LOAD : BUS_NONE);
        proc2mem_addr    = dc_grant ? dc_addr : (ic_grant ? ic_addr : '0);
        proc2mem_data    = dc_grant ? dc_wdata : '0;
        proc2mem_size    = dc_grant ? dc_size : (ic_grant ? DOUBLE : BYTE);
        dc_response      = dc_grant ? mem2proc_response : '0;
        ic_response      = ic_grant ? mem2proc_response : '0;
        alloc_en         = (proc2mem_command == BUS_LOAD) && (mem2proc_response != '0);
        dc_tag           = dc_hit ? mem2proc_tag : '0;
        dc_data          = dc_hit ? mem2proc_data : '0;
        ic_tag           = ic_hit ? mem2proc_tag : '0;
        ic_data          = ic_hit ? mem2proc_data : '0;
    end

    // count consecutive D-cache grants made while the I-cache is waiting
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            run_cnt <= '0;
        else if (ic_grant || !ic_req)
            run_cnt <= '0;
        else if (dc_grant && run_cnt != RW'(MAX_DC_RUN))
            run_cnt <= run_cnt + RW'(1);
    end

    mem_tag_table #(.NUM_TAGS(NUM_TAGS)) u_tag_table (
        .clock       (clock),
        .reset       (reset),
        .alloc_en    (alloc_en),
        .alloc_tag   (mem2proc_response),
        .alloc_owner (dc_grant ? REQ_DC : REQ_IC),
        .squash      (ic_squash),
        .ret_tag     (mem2proc_tag),
        .ic_hit      (ic_hit),
        .dc_hit      (dc_hit),
        .stray       (stray_tag)
    );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench for grant order, tag routing, squash, stores and reset
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ic_req = 1'b0, ic_squash = 1'b0;
    logic [31:0] ic_addr = '0, dc_addr = '0;
    logic [1:0]  dc_command = BUS_NONE, dc_size = 2'd1;
    logic [63:0] dc_wdata = '0, mem2proc_data = '0;
    mem_tag_t    mem2proc_response = '0, mem2proc_tag = '0;
    mem_tag_t    ic_response, ic_tag, dc_response, dc_tag;
    logic [63:0] ic_data, dc_data, proc2mem_data;
    logic [1:0]  proc2mem_command, proc2mem_size;
    logic [31:0] proc2mem_addr;
    logic        stray_tag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        mem_tag_t    tag;
        logic [63:0] data;
        logic        to_ic;
        logic        to_dc;
        logic        stray;
    } exp_t;
    exp_t sb[$];

    mem_bus_arbiter dut (
        .clock(clock), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_squash(ic_squash),
        .ic_response(ic_response), .ic_data(ic_data), .ic_tag(ic_tag),
        .dc_command(dc_command), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_size(dc_size),
        .dc_response(dc_response), .dc_data(dc_data), .dc_tag(dc_tag),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data), .proc2mem_size(proc2mem_size),
        .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
        .mem2proc_tag(mem2proc_tag), .stray_tag(stray_tag)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic ic, input logic [31:0] ia, input logic [1:0] dcmd,
                         input logic [31:0] da, input logic [63:0] wd, input mem_tag_t resp,
                         input mem_tag_t rtag, input logic [63:0] rdata, input logic sq);
        @(negedge clock);
        ic_req = ic;
        ic_addr = ia;
        dc_command = dcmd;
        dc_addr = da;
        dc_wdata = wd;
        mem2proc_response = resp;
        mem2proc_tag = rtag;
        mem2proc_data = rdata;
        ic_squash = sq;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, BUS_NONE, '0, '0, '0, '0, '0, 1'b0);
    endtask

    task automatic ret(input mem_tag_t t, input logic [63:0] d);
        drive(1'b0, '0, BUS_NONE, '0, '0, '0, t, d, 1'b0);
    endtask

    task automatic push(input mem_tag_t t, input logic [63:0] d, input logic ic,
                        input logic dc, input logic st);
        sb.push_back('{tag: t, data: d, to_ic: ic, to_dc: dc, stray: st});
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        check({name, "_sb_empty"}, 64'(sb.size() == 0), 64'd0);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({name, "_ic_tag"}, 64'(ic_tag), e.to_ic ? 64'(e.tag) : 64'd0);
            check({name, "_ic_data"}, ic_data, e.to_ic ? e.data : 64'd0);
            check({name, "_dc_tag"}, 64'(dc_tag), e.to_dc ? 64'(e.tag) : 64'd0);
            check({name, "_dc_data"}, dc_data, e.to_dc ? e.data : 64'd0);
            check({name, "_stray"}, 64'(stray_tag), 64'(e.stray));
        end
    endtask

    initial begin
        // requests and a return while reset is held must all be suppressed
        drive(1'b1, 32'h100, BUS_NONE, '0, '0, 4'd3, 4'd5, 64'h55, 1'b0);
        check("rst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        check("rst_ic_resp", 64'(ic_response), 64'd0);
        check("rst_stray", 64'(stray_tag), 64'd0);
        check("rst_ic_tag", 64'(ic_tag), 64'd0);
        idle();
        reset = 1'b0;

        // lone I-cache load, returned five cycles later
        drive(1'b1, 32'h100, BUS_NONE, '0, '0, 4'd3, '0, '0, 1'b0);
        check("t1_cmd", 64'(proc2mem_command), 64'(BUS_LOAD));
        check("t1_addr", 64'(proc2mem_addr), 64'h100);
        check("t1_size", 64'(proc2mem_size), 64'(DOUBLE));
        check("t1_data", proc2mem_data, 64'd0);
        check("t1_ic_resp", 64'(ic_response), 64'd3);
        check("t1_dc_resp", 64'(dc_response), 64'd0);
        push(4'd3, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 1'b0);
        repeat (4) idle();
        ret(4'd3, 64'h0123_4567_89AB_CDEF);
        pop_check("t1_ret");

        // contention: four D-cache grants, then the I-cache, then the D-cache again
        for (int i = 0; i < 6; i++) begin
            logic exp_dc;
            exp_dc = (i != 4);
            drive(1'b1, 32'h200 + 32'(i), BUS_LOAD, 32'h300 + 32'(i * 8), '0, 4'(i + 1), '0, '0, 1'b0);
            check($sformatf("t2_dc_resp%0d", i), 64'(dc_response), exp_dc ? 64'(i + 1) : 64'd0);
            check($sformatf("t2_ic_resp%0d", i), 64'(ic_response), exp_dc ? 64'd0 : 64'(i + 1));
            check($sformatf("t2_addr%0d", i), 64'(proc2mem_addr),
                  exp_dc ? 64'(32'h300 + 32'(i * 8)) : 64'(32'h200 + 32'(i)));
            push(4'(i + 1), 64'hB0 + 64'(i), !exp_dc, exp_dc, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            ret(4'(i + 1), 64'hB0 + 64'(i));
            pop_check($sformatf("t2_ret%0d", i));
        end

        // squash: tags 1,2 stale, return in squash cycle suppressed, same-cycle alloc stale too
        drive(1'b1, 32'h400, BUS_NONE, '0, '0, 4'd1, '0, '0, 1'b0);
        push(4'd1, 64'hC1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h404, BUS_NONE, '0, '0, 4'd2, '0, '0, 1'b0);
        push(4'd2, 64'hC2, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h408, BUS_NONE, '0, '0, 4'd8, 4'd1, 64'hC1, 1'b1);
        pop_check("t3_sq_ret1");
        check("t3_sq_ic_resp", 64'(ic_response), 64'd8);
        push(4'd8, 64'hC8, 1'b0, 1'b0, 1'b0);
        ret(4'd2, 64'hC2);
        pop_check("t3_ret2");
        ret(4'd8, 64'hC8);
        pop_check("t3_ret8");
        drive(1'b1, 32'h40C, BUS_NONE, '0, '0, 4'd4, '0, '0, 1'b0);
        check("t3_ic_resp4", 64'(ic_response), 64'd4);
        push(4'd4, 64'hC4, 1'b1, 1'b0, 1'b0);
        idle();
        ret(4'd4, 64'hC4);
        pop_check("t3_ret4");

        // store is not tracked: its tag coming back is stray for exactly one cycle
        drive(1'b0, '0, BUS_STORE, 32'h500, 64'hDEAD_BEEF_0000_0005, 4'd5, '0, '0, 1'b0);
        check("t4_cmd", 64'(proc2mem_command), 64'(BUS_STORE));
        check("t4_wdata", proc2mem_data, 64'hDEAD_BEEF_0000_0005);
        check("t4_size", 64'(proc2mem_size), 64'd1);
        check("t4_dc_resp", 64'(dc_response), 64'd5);
        idle();
        ret(4'd5, 64'hE5);
        push(4'd5, 64'hE5, 1'b0, 1'b0, 1'b1);
        pop_check("t4_stray");
        idle();
        check("t4_stray_clr", 64'(stray_tag), 64'd0);

        // tag 7 returns to the D-cache while the I-cache is granted tag 7
        drive(1'b0, '0, BUS_LOAD, 32'h600, '0, 4'd7, '0, '0, 1'b0);
        push(4'd7, 64'hF7, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 32'h700, BUS_NONE, '0, '0, 4'd7, 4'd7, 64'hF7, 1'b0);
        pop_check("t5_dc_ret");
        check("t5_ic_resp", 64'(ic_response), 64'd7);
        push(4'd7, 64'hF8, 1'b1, 1'b0, 1'b0);
        idle();
        ret(4'd7, 64'hF8);
        pop_check("t5_ic_ret");

        // asynchronous reset with tags 2 and 6 live
        drive(1'b1, 32'h800, BUS_NONE, '0, '0, 4'd2, '0, '0, 1'b0);
        drive(1'b0, '0, BUS_LOAD, 32'h900, '0, 4'd6, '0, '0, 1'b0);
        drive(1'b1, 32'h810, BUS_NONE, '0, '0, 4'd3, 4'd2, 64'h77, 1'b0);
        check("t6_pre_ic_tag", 64'(ic_tag), 64'd2);
        reset = 1'b1;
        #1;
        check("t6_rst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        check("t6_rst_ic_resp", 64'(ic_response), 64'd0);
        check("t6_rst_ic_tag", 64'(ic_tag), 64'd0);
        check("t6_rst_stray", 64'(stray_tag), 64'd0);
        idle();
        reset = 1'b0;
        push(4'd2, 64'h0, 1'b0, 1'b0, 1'b1);
        ret(4'd2, 64'h77);
        pop_check("t6_stray2");
        push(4'd6, 64'h0, 1'b0, 1'b0, 1'b1);
        ret(4'd6, 64'h66);
        pop_check("t6_stray6");
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
